// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue block: opcodes, funct codes, ALU ops,
// FSM state type and the instruction decode helper.
package alu_pkg;

    localparam logic [3:0] OPC_RTYPE = 4'b0000;
    localparam logic [3:0] OPC_ADDI  = 4'b0100;

    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_ADD = 3'b010;
    localparam logic [2:0] FN_SUB = 3'b110;
    localparam logic [2:0] FN_SLT = 3'b111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic        legal;
        logic        is_imm;
        logic [2:0]  op;
        logic [2:0]  dst;
        logic [15:0] imm;
    } decode_t;

    function automatic decode_t decode(input logic [15:0] word);
        decode_t d;
        d.legal  = 1'b0;
        d.is_imm = 1'b0;
        d.op     = ALU_AND;
        d.dst    = 3'd0;
        d.imm    = {{10{word[5]}}, word[5:0]};
        case (word[15:12])
            OPC_RTYPE: begin
                d.dst = word[5:3];
                case (word[2:0])
                    FN_AND: begin d.legal = 1'b1; d.op = ALU_AND; end
                    FN_OR:  begin d.legal = 1'b1; d.op = ALU_OR;  end
                    FN_ADD: begin d.legal = 1'b1; d.op = ALU_ADD; end
                    FN_SUB: begin d.legal = 1'b1; d.op = ALU_SUB; end
                    FN_SLT: begin d.legal = 1'b1; d.op = ALU_SLT; end
                    default: d.legal = 1'b0;
                endcase
            end
            OPC_ADDI: begin
                d.legal  = 1'b1;
                d.is_imm = 1'b1;
                d.op     = ALU_ADD;
                d.dst    = word[8:6];
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile8x16.sv
// 8 x 16 register file: two combinational read ports, a debug read port and
// one synchronous write port. r0 always reads zero and ignores writes.
module regfile8x16 #(
    parameter logic [15:0] REG_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  rd_addr_a,
    output logic [15:0] rd_data_a,
    input  logic [2:0]  rd_addr_b,
    output logic [15:0] rd_data_b,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data
);

    logic [15:0] regs [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs[0] <= '0;
            for (int i = 1; i < 8; i++) begin
                regs[i] <= REG_INIT;
            end
        end else if (wr_en && (wr_addr != 3'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == 3'd0) ? 16'h0000 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 3'd0) ? 16'h0000 : regs[rd_addr_b];
    assign dbg_data  = (dbg_addr  == 3'd0) ? 16'h0000 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Single-issue sequencer: accepts one instruction, drives the external ALU
// for one cycle, then reports and writes back the result.
module alu_issue
    import alu_pkg::*;
#(
    parameter logic [15:0] REG_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_sum,
    input  logic        alu_zero,
    output logic        wb_valid,
    output logic [2:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic        wb_zero,
    output logic        illegal,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    state_t      state;
    decode_t     dec;
    logic        ill_q;
    logic [2:0]  dst_q;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;

    assign dec = decode(instr);

    // Read ports are addressed straight from the offered word so operands
    // can be registered at the accepting edge.
    regfile8x16 #(.REG_INIT(REG_INIT)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (instr[11:9]),
        .rd_data_a (rd_data_a),
        .rd_addr_b (instr[8:6]),
        .rd_data_b (rd_data_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wb_valid),
        .wr_addr   (wb_reg),
        .wr_data   (wb_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            wb_valid    <= 1'b0;
            wb_reg      <= '0;
            wb_data     <= '0;
            wb_zero     <= 1'b0;
            illegal     <= 1'b0;
            ill_q       <= 1'b0;
            dst_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        state       <= EXEC;
                        instr_ready <= 1'b0;
                        dst_q       <= dec.dst;
                        ill_q       <= !dec.legal;
                        illegal     <= !dec.legal;
                        if (dec.legal) begin
                            alu_op <= dec.op;
                            alu_a  <= rd_data_a;
                            alu_b  <= dec.is_imm ? dec.imm : rd_data_b;
                        end
                    end
                end
                EXEC: begin
                    alu_op  <= '0;
                    alu_a   <= '0;
                    alu_b   <= '0;
                    illegal <= 1'b0;
                    if (ill_q) begin
                        state       <= IDLE;
                        instr_ready <= 1'b1;
                    end else begin
                        state    <= WB;
                        wb_valid <= 1'b1;
                        wb_reg   <= dst_q;
                        wb_data  <= alu_sum;
                        wb_zero  <= alu_zero;
                    end
                end
                WB: begin
                    wb_valid    <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural model of the external ALU.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_sum;
    logic        alu_zero;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        wb_zero;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sum     (alu_sum),
        .alu_zero    (alu_zero),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .wb_zero     (wb_zero),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU
    always_comb begin
        case (alu_op)
            3'b000:  alu_sum = alu_a & alu_b;
            3'b001:  alu_sum = alu_a | alu_b;
            3'b010:  alu_sum = alu_a + alu_b;
            3'b110:  alu_sum = alu_a - alu_b;
            3'b111:  alu_sum = {15'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_sum = 16'h0000;
        endcase
        alu_zero = (alu_sum == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // Issue one legal instruction and check every stage of its three-cycle life.
    task automatic issue(input string name, input logic [15:0] word,
                         input logic [2:0] e_op, input logic [15:0] e_a, input logic [15:0] e_b,
                         input logic [2:0] e_reg, input logic [15:0] e_data, input logic e_zero);
        wait_ready();
        instr = word;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 16'hF000;
        check({name, "_op"}, {29'd0, alu_op}, {29'd0, e_op});
        check({name, "_a"}, {16'd0, alu_a}, {16'd0, e_a});
        check({name, "_b"}, {16'd0, alu_b}, {16'd0, e_b});
        check({name, "_rdy_exec"}, {31'd0, instr_ready}, 32'd0);
        check({name, "_wbv_exec"}, {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        check({name, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        check({name, "_wbreg"}, {29'd0, wb_reg}, {29'd0, e_reg});
        check({name, "_wbdata"}, {16'd0, wb_data}, {16'd0, e_data});
        check({name, "_wbzero"}, {31'd0, wb_zero}, {31'd0, e_zero});
        check({name, "_alu_idle"}, {13'd0, alu_op, alu_a}, 32'd0);
        check({name, "_rdy_wb"}, {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        check({name, "_wbv_off"}, {31'd0, wb_valid}, 32'd0);
        check({name, "_rdy_back"}, {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic issue_illegal(input string name, input logic [15:0] word);
        wait_ready();
        instr = word;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check({name, "_pulse"}, {31'd0, illegal}, 32'd1);
        check({name, "_alu"}, {13'd0, alu_op, alu_a | alu_b}, 32'd0);
        check({name, "_wbv1"}, {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        check({name, "_pulse_off"}, {31'd0, illegal}, 32'd0);
        check({name, "_wbv2"}, {31'd0, wb_valid}, 32'd0);
        check({name, "_rdy"}, {31'd0, instr_ready}, 32'd1);
    endtask

    logic [15:0] rv;
    logic [15:0] exp_regs [8];
    int          accepts;

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0000;
        dbg_addr = 3'd0;
        #12;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_wb", {12'd0, wb_valid, wb_reg, wb_data}, 32'd0);
        check("rst_alu", {13'd0, alu_op, alu_a | alu_b}, 32'd0);
        check("rst_ill", {31'd0, illegal}, 32'd0);
        read_reg(3'd1, rv);
        check("rst_r1", {16'd0, rv}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue("addi_r1", 16'h4045, 3'b010, 16'h0000, 16'h0005, 3'd1, 16'h0005, 1'b0);
        issue("addi_r2", 16'h40BD, 3'b010, 16'h0000, 16'hFFFD, 3'd2, 16'hFFFD, 1'b0);
        read_reg(3'd1, rv); check("dbg_r1", {16'd0, rv}, 32'h0005);
        read_reg(3'd2, rv); check("dbg_r2", {16'd0, rv}, 32'hFFFD);
        issue("add_r3", 16'h029A, 3'b010, 16'h0005, 16'hFFFD, 3'd3, 16'h0002, 1'b0);
        issue("sub_r4", 16'h0266, 3'b110, 16'h0005, 16'h0005, 3'd4, 16'h0000, 1'b1);
        issue("slt_r5", 16'h046F, 3'b111, 16'hFFFD, 16'h0005, 3'd5, 16'h0001, 1'b0);
        issue("addi_r0", 16'h4007, 3'b010, 16'h0000, 16'h0007, 3'd0, 16'h0007, 1'b0);
        read_reg(3'd0, rv); check("dbg_r0", {16'd0, rv}, 32'h0000);
        read_reg(3'd3, rv); check("dbg_r3", {16'd0, rv}, 32'h0002);
        read_reg(3'd4, rv); check("dbg_r4", {16'd0, rv}, 32'h0000);
        read_reg(3'd5, rv); check("dbg_r5", {16'd0, rv}, 32'h0001);

        exp_regs[0] = 16'h0000; exp_regs[1] = 16'h0005; exp_regs[2] = 16'hFFFD;
        exp_regs[3] = 16'h0002; exp_regs[4] = 16'h0000; exp_regs[5] = 16'h0001;
        exp_regs[6] = 16'h0000; exp_regs[7] = 16'h0000;
        issue_illegal("ill_opc", 16'hF000);
        issue_illegal("ill_fn3", 16'h024B);
        for (int i = 0; i < 8; i++) begin
            read_reg(i[2:0], rv);
            check($sformatf("ill_keep_r%0d", i), {16'd0, rv}, {16'd0, exp_regs[i]});
        end

        // Back-to-back offers: ADDI r7,r0,1 held valid for nine cycles.
        wait_ready();
        @(negedge clk);
        instr = 16'h41C1;
        instr_valid = 1'b1;
        accepts = 0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("stream_rdy%0d", i), {31'd0, instr_ready}, {31'd0, (i % 3 == 0)});
            if (instr_ready) accepts++;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        check("stream_accepts", accepts, 32'd3);
        wait_ready();
        read_reg(3'd7, rv); check("stream_r7", {16'd0, rv}, 32'h0001);

        // Reset while ADD r6,r1,r1 is in EXEC.
        @(negedge clk);
        instr = 16'h0272;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("rstx_exec_a", {16'd0, alu_a}, 32'h0005);
        rst_n = 1'b0;
        #1;
        check("rstx_alu", {13'd0, alu_op, alu_a | alu_b}, 32'd0);
        check("rstx_wb", {11'd0, wb_valid, illegal, wb_reg, wb_data}, 32'd0);
        check("rstx_wbz", {31'd0, wb_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstx_ready", {31'd0, instr_ready}, 32'd1);
        check("rstx_wbv", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        check("rstx_wbv2", {31'd0, wb_valid}, 32'd0);
        read_reg(3'd6, rv); check("rstx_r6", {16'd0, rv}, 32'h0000);
        read_reg(3'd1, rv); check("rstx_r1", {16'd0, rv}, 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter REG_INIT, default 16'h0000: reset value of registers r1..r7.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port instr_valid, input, 1 bit: an instruction is offered.
REQ-005 SHALL have port instr, input, 16 bits: the offered instruction word.
REQ-006 SHALL have port instr_ready, output, 1 bit: the block accepts an instruction this cycle.
REQ-007 SHALL have port alu_op, output, 3 bits: operation select driven to the ALU.
REQ-008 SHALL have ports alu_a and alu_b, output, 16 bits each: ALU operands.
REQ-009 SHALL have ports alu_sum (input, 16 bits) and alu_zero (input, 1 bit): the combinational ALU result.
REQ-010 SHALL have ports wb_valid (output, 1 bit), wb_reg (output, 3 bits), wb_data (output, 16 bits) and wb_zero (output, 1 bit): the write-back report.
REQ-011 SHALL have port illegal, output, 1 bit: one-cycle pulse when an undecodable instruction is retired.
REQ-012 SHALL have ports dbg_addr (input, 3 bits) and dbg_data (output, 16 bits): combinational register read for the bench.

Function
REQ-013 SHALL decode R-type as opcode instr[15:12]=0000, rs=[11:9], rt=[8:6], rd=[5:3], funct=[2:0].
REQ-014 SHALL decode ADDI as opcode 0100, rs=[11:9], rt=[8:6] (destination), imm6=[5:0] sign-extended to 16 bits.
REQ-015 SHALL map funct to alu_op: 000 AND->000, 001 OR->001, 010 ADD->010, 110 SUB->110, 111 SLT->111; ADDI SHALL use 010.
REQ-016 SHALL treat any other opcode, and funct 011/100/101, as illegal.
REQ-017 SHALL implement FSM states IDLE, EXEC, WB; reset state IDLE.
REQ-018 SHALL assert instr_ready only in IDLE; handshake on instr_valid && instr_ready moves IDLE->EXEC and latches the decoded fields.
REQ-019 SHALL drive alu_a=R[rs] and alu_b=R[rt] (R-type) or the sign-extended imm (ADDI) during EXEC, and drive alu_op/alu_a/alu_b to zero in all other states.
REQ-020 SHALL capture alu_sum and alu_zero at the end of EXEC and move EXEC->WB.
REQ-021 SHALL, in WB, assert wb_valid for exactly one cycle with wb_reg/wb_data/wb_zero, write wb_data into R[wb_reg] at that edge, then return to IDLE.
REQ-022 SHALL, for an illegal instruction, skip ALU drive, pulse illegal in the cycle after acceptance, perform no write and no wb_valid, and return to IDLE.
REQ-023 SHALL give latency: accepted at edge N -> ALU driven in cycle N+1 -> wb_valid in cycle N+2 -> instr_ready high again in cycle N+3.
REQ-024 SHALL keep r0 reading 0; a write to r0 SHALL still report wb_valid with the ALU result but leave r0 at 0.
REQ-025 SHALL wrap arithmetic modulo 2^16 with no overflow flag; SLT semantics come entirely from the ALU.
REQ-026 SHALL ignore instr while instr_ready is low, with no side effects.

Reset
REQ-027 SHALL, on rst_n low, immediately force IDLE, r1..r7=REG_INIT, wb_valid=0, illegal=0, wb_reg=0, wb_data=0, wb_zero=0, and alu_op/alu_a/alu_b=0.
REQ-028 SHALL, on reset asserted mid-EXEC or mid-WB, abort the instruction with no register write; instr_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-029 SHALL place opcode, funct and ALU op constants and the FSM state type in shared package alu_pkg.
REQ-030 SHALL implement registers in sub-module regfile8x16 (two combinational read ports plus the dbg read port, one synchronous write port, r0 hardwired to 0).
REQ-031 SHALL connect to the existing 16-bit ALU externally; the ALU SHALL NOT be instantiated inside this block.

Verification
REQ-032 SHALL cover ADDI r1,r0,5 then ADDI r2,r0,-3 -> wb_data 0x0005 then 0xFFFD, with dbg r1=5 and r2=0xFFFD.
REQ-033 SHALL cover ADD r3,r1,r2 -> alu_op=010 in EXEC, wb_data=0x0002, wb_zero=0; SUB r4,r1,r1 -> 0x0000, wb_zero=1.
REQ-034 SHALL cover SLT r5,r2,r1 -> wb_data=0x0001, and ADDI r0,r0,7 -> wb_valid with 0x0007 while dbg r0 stays 0.
REQ-035 SHALL cover instr=0xF000 -> illegal pulses once, no wb_valid, all registers unchanged.
REQ-036 SHALL cover instr_valid held high continuously -> one acceptance every 3 cycles, instr_ready low in EXEC and WB.
REQ-037 SHALL cover rst_n low during EXEC of ADD r6,r1,r1 -> r6 not written, all outputs 0, instr_ready=1 after release.
